// File: rtl/digit_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_pkg
//  Description : Shared constants, scan-state type and width helper for the
//                seven-segment digit scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package digit_scan_pkg;

    // Code sent to the BCD-to-seven-segment decoder to turn a digit fully off.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Phase of the current digit slot.
    typedef enum logic [0:0] {
        GUARD = 1'b0,   // all enables low, anti-ghosting gap
        SHOW  = 1'b1    // one digit enabled
    } scan_state_t;

    // Ceil(log2(value)), never less than 1 so a vector is always declarable.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_timer
//  Description : Slot counter and digit index for the display scan.
//                Counter runs 0..DIV-1; the first BLANK_CYCLES counts of each
//                slot are the guard phase. The index advances on each counter
//                wrap and itself wraps after NUM_DIGITS-1.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                o_guard         - current count lies in the guard phase
//                o_idx           - digit index of the current slot
//                o_frame_wrap    - last count of the last digit (commit point)
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_timer
    import digit_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int IDX_W        = clog2_min1(NUM_DIGITS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic                  o_guard,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_frame_wrap
);

    localparam int CNT_W = clog2_min1(DIV);

    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_blank = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_slot_wrap;

    assign w_slot_wrap  = (r_cnt == c_cnt_last);
    assign o_guard      = (r_cnt < c_cnt_blank);
    assign o_idx        = r_idx;
    assign o_frame_wrap = w_slot_wrap && (r_idx == c_idx_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/digit_scan.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan
//  Description : Time-multiplexed scan controller for a multi-digit
//                seven-segment display. Loads land in a shadow register and
//                are committed to the displayed value only at the frame
//                boundary so a frame never mixes old and new digits.
//                Optional macro DIGIT_SCAN_LZB_EN enables leading-zero
//                blanking (digit 0 is always shown).
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                bcd_in       - packed BCD value, digit 0 in bits [3:0]
//                load         - capture bcd_in this cycle
//                num          - digit code to decoder, 4'hF = blank
//                digit_en     - one-hot digit enable, zero during guard
//                frame_done   - one-cycle pulse after a value is committed
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_scan
    import digit_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  wire logic                      load,
    output logic [3:0]                     num,
    output logic [NUM_DIGITS-1:0]          digit_en,
    output logic                           frame_done
);

    localparam int IDX_W = clog2_min1(NUM_DIGITS);

    logic                    w_guard;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_frame_wrap;
    scan_state_t             w_state;

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_pending;
    logic                    r_commit_d;
    logic [3:0]              r_num;
    logic [NUM_DIGITS-1:0]   r_digit_en;
    logic                    r_frame_done;

    logic [3:0]              w_digit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_show_code;

    scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_guard      (w_guard),
        .o_idx        (w_idx),
        .o_frame_wrap (w_frame_wrap)
    );

    assign w_state = w_guard ? GUARD : SHOW;

    // Digit select and one-hot decode; the loop form keeps index values that
    // can never occur (non power-of-two NUM_DIGITS) harmlessly blank.
    always_comb begin
        w_digit  = BLANK_CODE;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_digit     = r_active[4*i +: 4];
                w_onehot[i] = 1'b1;
            end
        end
    end

`ifdef DIGIT_SCAN_LZB_EN
    // w_upper_zero[k]: digits k..NUM_DIGITS-1 of the active value are all 0.
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic                  w_lzb_blank;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lzb
        assign w_upper_zero[k] = ~|r_active[4*NUM_DIGITS-1:4*k];
    end

    // Digit 0 is excluded so a zero value still shows a single "0".
    always_comb begin
        w_lzb_blank = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if ((w_idx == IDX_W'(i)) && w_upper_zero[i]) begin
                w_lzb_blank = 1'b1;
            end
        end
    end

    assign w_show_code = w_lzb_blank ? BLANK_CODE : w_digit;
`else
    assign w_show_code = w_digit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_commit_d   <= 1'b0;
            r_num        <= BLANK_CODE;
            r_digit_en   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_state == GUARD) begin
                r_num      <= BLANK_CODE;
                r_digit_en <= '0;
            end else begin
                r_num      <= w_show_code;
                r_digit_en <= w_onehot;
            end

            // Commit is noted here and reported one cycle later so the pulse
            // lines up with the first guard cycle of digit 0.
            r_frame_done <= r_commit_d;

            if (w_frame_wrap) begin
                // A load on the commit cycle bypasses the shadow register.
                if (load) begin
                    r_active <= bcd_in;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
                r_commit_d <= load || r_pending;
                r_pending  <= 1'b0;
            end else begin
                r_commit_d <= 1'b0;
                if (load) begin
                    r_shadow  <= bcd_in;
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign num        = r_num;
    assign digit_en   = r_digit_en;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_scan
//  Description : Self-checking bench for digit_scan (NUM_DIGITS=4, DIV=10,
//                BLANK_CYCLES=2). A cycle-position model derives the expected
//                outputs each clock; directed literal checks pin the model.
//                Honours DIGIT_SCAN_LZB_EN in its expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan;

    localparam int N     = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

`ifdef DIGIT_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [15:0]   bcd_in;
    logic          load;
    logic [3:0]    num;
    logic [N-1:0]  digit_en;
    logic          frame_done;

    int n_total;
    int n_pass;
    int cyc;

    digit_scan #(
        .NUM_DIGITS   (N),
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .load       (load),
        .num        (num),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge number since reset release: first edge after release is 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Expected outputs after each edge follow from the edge's position in the
    // frame: slot = pos / DIV, offset = pos % DIV, guard when offset < BLANK.
    int          m_edges;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pending;
    bit          m_commit_prev;
    logic [3:0]  exp_num;
    logic [N-1:0] exp_en;
    logic        exp_fd;

    always @(posedge clk or negedge rst_n) begin : model
        int pos, slot, off;
        logic [3:0] dig;
        if (!rst_n) begin
            m_edges       <= 0;
            m_active      <= '0;
            m_shadow      <= '0;
            m_pending     <= 1'b0;
            m_commit_prev <= 1'b0;
            exp_num       <= 4'hF;
            exp_en        <= '0;
            exp_fd        <= 1'b0;
        end else begin
            pos  = m_edges % FRAME;
            slot = pos / DIV;
            off  = pos % DIV;
            dig  = m_active[4*slot +: 4];
            if (LZB && slot > 0 && (m_active >> (4*slot)) == 16'h0) dig = 4'hF;
            if (off < BLANK) begin
                exp_en  <= '0;
                exp_num <= 4'hF;
            end else begin
                exp_en  <= N'(1 << slot);
                exp_num <= dig;
            end
            exp_fd <= m_commit_prev;
            if (pos == FRAME - 1) begin
                if (load)           m_active <= bcd_in;
                else if (m_pending) m_active <= m_shadow;
                m_commit_prev <= load || m_pending;
                m_pending     <= 1'b0;
            end else begin
                m_commit_prev <= 1'b0;
                if (load) begin
                    m_shadow  <= bcd_in;
                    m_pending <= 1'b1;
                end
            end
            m_edges <= m_edges + 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        check("num",        32'(num),               32'(exp_num));
        check("digit_en",   32'(digit_en),          32'(exp_en));
        check("frame_done", 32'(frame_done),        32'(exp_fd));
        check("onehot0",    32'($onehot0(digit_en)), 32'd1);
    end

    // ---------------- directed helpers ----------------
    task automatic go_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a load so that it is sampled by edge k.
    task automatic load_at(input int k, input logic [15:0] v);
        go_to(k - 1);
        @(negedge clk);
        bcd_in = v;
        load   = 1'b1;
        go_to(k);
        load   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        n_total = 0;
        n_pass  = 0;
        load    = 1'b0;
        bcd_in  = '0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_num", 32'(num), 32'hF);
        check("rst_en",  32'(digit_en), 32'h0);
        check("rst_fd",  32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // First frame, reset value 0.
        go_to(1);  check("c1_en",  32'(digit_en), 32'h0); check("c1_num", 32'(num), 32'hF);
        go_to(3);  check("c3_en",  32'(digit_en), 32'h1); check("c3_num", 32'(num), 32'h0);
        load_at(5, 16'h1234);
        go_to(10); check("c10_num", 32'(num), 32'h0);
        go_to(11); check("c11_en", 32'(digit_en), 32'h0);
        go_to(13); check("c13_en", 32'(digit_en), 32'h2);
        go_to(40); check("c40_fd", 32'(frame_done), 32'h0);
        go_to(41); check("c41_fd", 32'(frame_done), 32'h1); check("c41_en", 32'(digit_en), 32'h0);
        go_to(42); check("c42_fd", 32'(frame_done), 32'h0);
        go_to(43); check("c43_num", 32'(num), 32'h4); check("c43_en", 32'(digit_en), 32'h1);

        // Two loads in one frame: the later one wins.
        load_at(50, 16'h1111);
        go_to(53); check("c53_num", 32'(num), 32'h3);
        load_at(60, 16'h5678);
        go_to(63); check("c63_num", 32'(num), 32'h2);
        go_to(81); check("c81_fd", 32'(frame_done), 32'h1);
        go_to(82); check("c82_fd", 32'(frame_done), 32'h0);
        go_to(83); check("c83_num", 32'(num), 32'h8);
        go_to(113); check("c113_num", 32'(num), 32'h5);

        // Load on the commit cycle goes straight to the display.
        load_at(120, 16'h0909);
        go_to(121); check("c121_fd", 32'(frame_done), 32'h1);
        go_to(123); check("c123_num", 32'(num), 32'h9);
        go_to(133); check("c133_num", 32'(num), 32'h0);

        // Leading zeros.
        load_at(150, 16'h0050);
        go_to(161); check("c161_fd", 32'(frame_done), 32'h1);
        go_to(163); check("lz_s0", 32'(num), 32'h0);
        go_to(173); check("lz_s1", 32'(num), 32'h5);
        go_to(183); check("lz_s2", 32'(num), LZB ? 32'hF : 32'h0); check("lz_s2_en", 32'(digit_en), 32'h4);
        go_to(193); check("lz_s3", 32'(num), LZB ? 32'hF : 32'h0); check("lz_s3_en", 32'(digit_en), 32'h8);
        load_at(200, 16'h0000);
        go_to(203); check("z_s0", 32'(num), 32'h0);
        go_to(213); check("z_s1", 32'(num), LZB ? 32'hF : 32'h0);

        // Digit codes above 9 pass through.
        load_at(240, 16'hABCD);
        go_to(243); check("hex_s0", 32'(num), 32'hD);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load   = ($urandom_range(0, 11) == 0);
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) bcd_in = bcd_in & 16'h00FF;
            if ($urandom_range(0, 7) == 0) bcd_in = 16'h0000;
        end
        @(negedge clk);
        load = 1'b0;

        // Reset mid-frame drops a pending load.
        do_reset();
        load_at(20, 16'h1234);
        go_to(25);
        check("c25_en_pre", 32'(digit_en), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_num", 32'(num), 32'hF);
        check("mid_rst_en",  32'(digit_en), 32'h0);
        check("mid_rst_fd",  32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        go_to(41); check("post_rst_fd", 32'(frame_done), 32'h0);
        go_to(43); check("post_rst_num", 32'(num), 32'h0);
        go_to(53); check("post_rst_num1", 32'(num), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
